// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data-memory and byte-wide RAM signals around mem_arbiter.
// master = requesters plus RAM (the environment), slave = the arbiter itself.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        busy;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a byte RAM: n-byte little-endian transfers, done n+2 (read) / n+1 (write) after accept.
// Requesters hold req until done; MEM beats IF on ties, or round-robin with ARB_RR_EN defined.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_base, r_wdata, r_buf, r_if_data, r_mem_rdata;
  logic        r_we, r_own_mem, r_last_mem;
  logic [1:0]  r_idx, r_last_idx;
  logic        w_grant, w_grant_mem, w_tie;
  logic [1:0]  w_last_idx, w_prev_idx;
  logic [31:0] w_word;

  always_comb begin
    w_grant = bus.if_req | bus.mem_req;
    w_tie   = bus.if_req & bus.mem_req;
`ifdef ARB_RR_EN
    w_grant_mem = bus.mem_req & (~bus.if_req | ~r_last_mem);
`else
    w_grant_mem = bus.mem_req;
`endif
    w_last_idx = 2'd3;
    if (w_grant_mem && bus.mem_len == 2'd0) w_last_idx = 2'd0;
    if (w_grant_mem && bus.mem_len == 2'd1) w_last_idx = 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = XFER;
      XFER:    if (r_idx == r_last_idx) w_state_nxt = r_we ? DONE : WAIT;
      WAIT:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Final read byte arrives in WAIT; merge it straight into the result word.
  always_comb begin
    w_prev_idx = r_idx - 2'd1;
    w_word     = r_buf;
    w_word[{r_last_idx, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_we        <= 1'b0;
      r_own_mem   <= 1'b0;
      r_last_mem  <= 1'b0;
      r_idx       <= '0;
      r_last_idx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_grant) begin
          r_base     <= w_grant_mem ? bus.mem_addr : bus.if_addr;
          r_wdata    <= w_grant_mem ? bus.mem_wdata : '0;
          r_we       <= w_grant_mem & bus.mem_we;
          r_own_mem  <= w_grant_mem;
          r_last_idx <= w_last_idx;
          r_idx      <= '0;
          r_buf      <= '0;
          // Only contested grants advance the round-robin pointer.
          if (w_tie) r_last_mem <= w_grant_mem;
        end
        XFER: begin
          r_idx <= r_idx + 2'd1;
          if (!r_we && r_idx != 2'd0) r_buf[{w_prev_idx, 3'b000} +: 8] <= bus.ram_din;
        end
        WAIT: begin
          if (r_own_mem) r_mem_rdata <= w_word;
          else           r_if_data   <= w_word;
        end
        default: ;
      endcase
    end
  end

  // RAM strobes are decoded from state so a reset drops them without a clock.
  assign bus.ram_wr    = (r_state == XFER) & r_we;
  assign bus.ram_a     = (r_state == XFER) ? r_base + {30'd0, r_idx} : '0;
  assign bus.ram_dout  = (r_state == XFER) ? r_wdata[{r_idx, 3'b000} +: 8] : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.if_done   = (r_state == DONE) & ~r_own_mem;
  assign bus.mem_done  = (r_state == DONE) & r_own_mem;
  assign bus.if_data   = r_if_data;
  assign bus.mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 256-byte RAM model aliased on ram_a[7:0].
module tb_mem_arbiter;
  logic clk;
  logic rst;
  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0] ram [256];
  int n_chk, n_bad;
  int mc, ic, mn, inn;
  logic [2:0] exp_mem_win;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[8'h00] <= 8'h13; ram[8'h01] <= 8'h05; ram[8'h02] <= 8'h10; ram[8'h03] <= 8'h00;
      ram[8'h04] <= 8'hEF; ram[8'h05] <= 8'hBE; ram[8'h06] <= 8'hAD; ram[8'h07] <= 8'hDE;
      ram[8'hFF] <= 8'h80;
      bus.ram_din <= 8'h00;
    end else begin
      bus.ram_din <= ram[bus.ram_a[7:0]];
      if (bus.ram_wr) ram[bus.ram_a[7:0]] <= bus.ram_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
`ifdef ARB_RR_EN
    exp_mem_win = 3'b101;
`else
    exp_mem_win = 3'b111;
`endif
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
    bus.mem_len = '0; bus.mem_wdata = '0;
    #3;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr}, 0);
    chk("rst_if_done", {31'd0, bus.if_done}, 0);
    chk("rst_mem_done", {31'd0, bus.mem_done}, 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_ram_a", bus.ram_a, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 4-byte fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) chk("f_ram_a", bus.ram_a, 32'h0000_1000 + c - 1);
      if (c == 5) chk("f_wait_no_done", {31'd0, bus.if_done}, 0);
    end
    chk("f_done", {31'd0, bus.if_done}, 1);
    chk("f_data", bus.if_data, 32'h0010_0513);
    bus.if_req = 1'b0;

    // Back-to-back fetch: one IDLE cycle then the next ram_a
    @(negedge clk);
    chk("b2b_idle_busy", {31'd0, bus.busy}, 0);
    chk("b2b_no_dup_done", {31'd0, bus.if_done}, 0);
    chk("b2b_idle_ram_a", bus.ram_a, 0);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1004;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("b2b_ram_a", bus.ram_a, 32'h0000_1004);
    end
    chk("b2b_done", {31'd0, bus.if_done}, 1);
    chk("b2b_data", bus.if_data, 32'hDEAD_BEEF);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("b2b_done_once", {31'd0, bus.if_done}, 0);

    // 2-byte store
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd1;
    bus.mem_addr = 32'h20; bus.mem_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("st_wr1", {31'd0, bus.ram_wr}, 1);
    chk("st_a1", bus.ram_a, 32'h20);
    chk("st_d1", {24'd0, bus.ram_dout}, 32'hDD);
    @(negedge clk);
    chk("st_wr2", {31'd0, bus.ram_wr}, 1);
    chk("st_a2", bus.ram_a, 32'h21);
    chk("st_d2", {24'd0, bus.ram_dout}, 32'hCC);
    @(negedge clk);
    chk("st_done", {31'd0, bus.mem_done}, 1);
    chk("st_wr_off", {31'd0, bus.ram_wr}, 0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("st_ram", {8'd0, ram[8'h22], ram[8'h21], ram[8'h20]}, 32'h00CC_DD);

    // 1-byte load at the top of the address space
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
    bus.mem_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ld_ram_a", bus.ram_a, 32'hFFFF_FFFF);
    chk("ld_no_wr", {31'd0, bus.ram_wr}, 0);
    @(negedge clk);
    chk("ld_wait_no_done", {31'd0, bus.mem_done}, 0);
    @(negedge clk);
    chk("ld_done", {31'd0, bus.mem_done}, 1);
    chk("ld_rdata", bus.mem_rdata, 32'h0000_0080);
    bus.mem_req = 1'b0;
    @(negedge clk);

    // Three simultaneous fetch/store pairs
    for (int r = 0; r < 3; r++) begin
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
      bus.mem_addr = 32'h40 + r; bus.mem_wdata = 32'h5A + r;
      mc = 0; ic = 0; mn = 0; inn = 0;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (bus.mem_done) begin mn++; mc = c; bus.mem_req = 1'b0; end
        if (bus.if_done) begin
          inn++; ic = c; bus.if_req = 1'b0;
          chk("tie_if_data", bus.if_data, 32'h0010_0513);
        end
      end
      chk("tie_mem_cnt", mn, 1);
      chk("tie_if_cnt", inn, 1);
      chk("tie_mem_cyc", mc, exp_mem_win[r] ? 2 : 9);
      chk("tie_if_cyc", ic, exp_mem_win[r] ? 9 : 6);
      chk("tie_ram", {24'd0, ram[8'h40 + r]}, 32'h5A + r);
    end

    // Reset in the middle of a 4-byte store
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h30; bus.mem_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("rs_wr_c1", {31'd0, bus.ram_wr}, 1);
    @(negedge clk);
    chk("rs_a_c2", bus.ram_a, 32'h31);
    rst = 1'b0;
    #1;
    chk("rs_wr_drop", {31'd0, bus.ram_wr}, 0);
    chk("rs_busy", {31'd0, bus.busy}, 0);
    chk("rs_ram_a", bus.ram_a, 0);
    chk("rs_rdata_clr", bus.mem_rdata, 0);
    @(negedge clk);
    chk("rs_no_done", {31'd0, bus.mem_done}, 0);
    rst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) chk("rs_restart_a", bus.ram_a, 32'h30);
      if (c == 1) chk("rs_restart_d", {24'd0, bus.ram_dout}, 32'h44);
      if (c == 4) chk("rs_last_a", bus.ram_a, 32'h33);
    end
    chk("rs_done", {31'd0, bus.mem_done}, 1);
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("rs_done_once", {31'd0, bus.mem_done}, 0);
    chk("rs_ram", {ram[8'h33], ram[8'h32], ram[8'h31], ram[8'h30]}, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
